muldiv_iter_unit: RTL and testbench

Parametrised iterative multiply/divide execution unit for the pipelined RISC core. It replaces fixed single-cycle MUL/DIV with a WIDTH-generic shift-add multiplier and a restoring divider. It adds a valid/ready handshake, upper-half product, remainder, divide-by-zero signalling and a flush. The decode stage issues MUL (opcode 001010) and DIV (opcode 001011) class ops here. The writeback stage consumes the result and destination tag.

---
 rtl/muldiv_iter_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_iter_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter_unit.sv
// Iterative unsigned multiply/divide unit with valid/ready handshake.
// MUL/MULH use a shift-add over one multiplier bit per cycle; DIV/REM use a
// restoring divider producing one quotient bit per cycle, MSB first.
// Divide-by-zero completes on the accept edge with a defined result.
module muldiv_iter_unit #(
    parameter  int WIDTH = 32,
    parameter  int TAG_W = 5,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dz,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [TAG_W-1:0]   tag_q;
    logic               dz_q;

    // Multiplier: upper half accumulates partial products, lower half holds
    // the not-yet-consumed multiplier bits and fills with product bits.
    logic [2*WIDTH-1:0] acc_q;
    // Divider: partial remainder needs one extra bit for the shifted-in digit.
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   quo_q;

    logic               accept;
    logic               div_by_zero;
    logic               last_iter;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH:0]     div_rem_next;
    logic [WIDTH-1:0]   div_quo_next;

    // Flush in IDLE suppresses a same-edge accept.
    assign accept      = in_valid && (state_q == IDLE) && !flush;
    assign div_by_zero = in_op[1] && (in_b == '0);
    assign last_iter   = (cnt_q == CNT_W'(1));

    // One iteration of each datapath, evaluated from the current registers.
    assign mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_next     = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_shift    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign div_ge       = (div_shift >= {1'b0, b_q});
    assign div_rem_next = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;
    assign div_quo_next = {quo_q[WIDTH-2:0], div_ge};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush outranks both completion and consumption.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = div_by_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration counter and datapath iteration.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: these are plain registers, not a memory array, so they take
        // the async reset like the rest of the state.
        if (!rst) begin
            cnt_q <= '0;
            op_q  <= OP_MUL;
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
            dz_q  <= 1'b0;
            acc_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
        end else if (accept) begin
            cnt_q <= CNT_W'(WIDTH);
            op_q  <= in_op;
            a_q   <= in_a;
            b_q   <= in_b;
            tag_q <= in_tag;
            dz_q  <= div_by_zero;
            acc_q <= {{WIDTH{1'b0}}, in_b};
            rem_q <= '0;
            quo_q <= in_a;
        end else if (state_q == BUSY) begin
            if (flush) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (!op_q[1]) begin
                    acc_q <= mul_next;
                end else begin
                    rem_q <= div_rem_next;
                    quo_q <= div_quo_next;
                end
            end
        end
    end

    // Handshake and result outputs; results are zero outside DONE.
    always_comb begin
        in_ready   = (state_q == IDLE);
        busy       = (state_q != IDLE);
        out_valid  = (state_q == DONE);
        out_result = '0;
        out_tag    = '0;
        out_dz     = 1'b0;
        if (state_q == DONE) begin
            out_tag = tag_q;
            out_dz  = dz_q;
            if (dz_q) begin
                out_result = (op_q == OP_DIV) ? '1 : a_q;
            end else begin
                unique case (op_q)
                    OP_MUL:  out_result = acc_q[WIDTH-1:0];
                    OP_MULH: out_result = acc_q[2*WIDTH-1:WIDTH];
                    OP_DIV:  out_result = quo_q;
                    OP_REM:  out_result = rem_q[WIDTH-1:0];
                    default: out_result = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench: two instances (WIDTH=32 and WIDTH=8) driven with
// directed and random ops, compared against a plain-arithmetic model.
module tb_muldiv_iter_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  in_op;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_ready;

    logic        v32, rdy32, ov32, dz32, busy32;
    logic [31:0] a32, b32, res32;
    logic [4:0]  tag32;

    logic        v8, rdy8, ov8, dz8, busy8;
    logic [7:0]  a8, b8, res8;
    logic [4:0]  tag8;

    int vectors;
    int miscompares;

    muldiv_iter_unit #(.WIDTH(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_op(in_op),
        .in_a(a32), .in_b(b32), .in_tag(in_tag), .flush(flush),
        .out_valid(ov32), .out_ready(out_ready), .out_result(res32),
        .out_tag(tag32), .out_dz(dz32), .busy(busy32)
    );

    muldiv_iter_unit #(.WIDTH(8), .TAG_W(5)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_op(in_op),
        .in_a(a8), .in_b(b8), .in_tag(in_tag), .flush(flush),
        .out_valid(ov8), .out_ready(out_ready), .out_result(res8),
        .out_tag(tag8), .out_dz(dz8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: unsigned arithmetic on w-bit operands.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
        logic [63:0] mask;
        logic [63:0] prod;
        mask = (64'd1 << w) - 64'd1;
        prod = 64'(a) * 64'(b);
        case (op)
            2'b00:   return prod & mask;
            2'b01:   return (prod >> w) & mask;
            2'b10:   return (b == 0) ? mask : 64'(a / b);
            default: return (b == 0) ? 64'(a) : 64'(a % b);
        endcase
    endfunction

    function automatic logic get_ov(input int w);
        return (w == 32) ? ov32 : ov8;
    endfunction
    function automatic logic get_rdy(input int w);
        return (w == 32) ? rdy32 : rdy8;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 32) ? busy32 : busy8;
    endfunction
    function automatic logic get_dz(input int w);
        return (w == 32) ? dz32 : dz8;
    endfunction
    function automatic logic [31:0] get_res(input int w);
        return (w == 32) ? res32 : {24'b0, res8};
    endfunction
    function automatic logic [4:0] get_tag(input int w);
        return (w == 32) ? tag32 : tag8;
    endfunction

    // Drive request fields onto the selected instance (called at #1 after an edge).
    task automatic drive(input int w, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        in_op  = op;
        in_tag = tag;
        if (w == 32) begin
            a32 = a; b32 = b; v32 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; v8 = 1'b1;
        end
    endtask

    task automatic release_req();
        v32 = 1'b0;
        v8  = 1'b0;
    endtask

    // Full transaction: accept, measure latency, check result, hold, consume.
    task automatic run_op(input int w, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input int hold);
        logic [63:0] exp;
        logic        exp_dz;
        int          lat;
        logic [31:0] am, bm;
        am = (w == 32) ? a : {24'b0, a[7:0]};
        bm = (w == 32) ? b : {24'b0, b[7:0]};
        exp    = model(op, am, bm, w);
        exp_dz = op[1] && (bm == 0);
        check("ready_before_accept", 64'(get_rdy(w)), 64'd1);
        drive(w, op, am, bm, tag);
        @(posedge clk); #1;
        release_req();
        // lat counts edges including the accept edge.
        lat = 1;
        while (!get_ov(w) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), exp_dz ? 64'd1 : 64'(w + 1));
        check("result", 64'(get_res(w)), exp);
        check("tag", 64'(get_tag(w)), 64'(tag));
        check("dz", 64'(get_dz(w)), 64'(exp_dz));
        check("ready_in_done", 64'(get_rdy(w)), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(get_ov(w)), 64'd1);
            check("hold_result", 64'(get_res(w)), exp);
            check("hold_tag", 64'(get_tag(w)), 64'(tag));
            check("hold_ready", 64'(get_rdy(w)), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consumed_valid", 64'(get_ov(w)), 64'd0);
        check("consumed_ready", 64'(get_rdy(w)), 64'd1);
    endtask

    initial begin
        int seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b0;
        in_op     = 2'b00;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        v32 = 1'b0; a32 = '0; b32 = '0;
        v8  = 1'b0; a8  = '0; b8  = '0;

        #12;
        check("rst_ready", 64'(rdy32), 64'd1);
        check("rst_valid", 64'(ov32), 64'd0);
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_result", 64'(res32), 64'd0);
        check("rst_ready8", 64'(rdy8), 64'd1);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Directed WIDTH=32 cases.
        run_op(32, 2'b00, 32'd10, 32'd5, 5'd3, 0);
        run_op(32, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
        run_op(32, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1);
        run_op(32, 2'b10, 32'd10, 32'd5, 5'd9, 0);
        run_op(32, 2'b11, 32'd17, 32'd5, 5'd10, 0);
        run_op(32, 2'b10, 32'd5, 32'd10, 5'd11, 0);
        run_op(32, 2'b11, 32'd5, 32'd10, 5'd12, 0);
        run_op(32, 2'b10, 32'd10, 32'd0, 5'd13, 0);
        run_op(32, 2'b11, 32'd10, 32'd0, 5'd14, 0);
        // Backpressure for 7 cycles.
        run_op(32, 2'b00, 32'd1234, 32'd5678, 5'd15, 7);

        // Flush 10 edges into a DIV.
        drive(32, 2'b10, 32'd1000, 32'd7, 5'd2);
        @(posedge clk); #1;
        release_req();
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy32), 64'd0);
        check("flush_ready", 64'(rdy32), 64'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ov32) seen++;
        end
        check("flush_no_valid", 64'(seen), 64'd0);
        run_op(32, 2'b10, 32'd1000, 32'd7, 5'd4, 0);

        // Flush in IDLE suppresses the same-edge accept.
        drive(32, 2'b00, 32'd3, 32'd3, 5'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        release_req();
        flush = 1'b0;
        check("idle_flush_busy", 64'(busy32), 64'd0);

        // Async reset mid-MUL.
        drive(32, 2'b00, 32'd99, 32'd77, 5'd6);
        @(posedge clk); #1;
        release_req();
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_valid", 64'(ov32), 64'd0);
        check("arst_busy", 64'(busy32), 64'd0);
        check("arst_ready", 64'(rdy32), 64'd1);
        check("arst_result", 64'(res32), 64'd0);
        check("arst_tag", 64'(tag32), 64'd0);
        check("arst_dz", 64'(dz32), 64'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        run_op(32, 2'b00, 32'd99, 32'd77, 5'd6, 0);

        // WIDTH=8 directed.
        run_op(8, 2'b00, 32'd200, 32'd3, 5'd21, 0);
        run_op(8, 2'b01, 32'd200, 32'd3, 5'd22, 0);
        run_op(8, 2'b10, 32'd200, 32'd0, 5'd23, 0);

        // Randomized on both widths.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            run_op(32, rop, ra, rb, 5'($urandom), $urandom_range(0, 3));
        end
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_op(8, rop, ra, rb, 5'($urandom), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
